// File: rtl/rom_port_arbiter.sv
// ============================================================================
//  Module   : rom_port_arbiter
//  Purpose  : Shares one combinational instruction ROM between a CPU fetch
//             port and a debug/monitor read port. At most one request is
//             accepted per cycle. Read data returns exactly two edges after
//             acceptance, in acceptance order.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    STARVE_LIMIT     Cycles (1..15) a debug request may wait under fetch
//                     traffic before it is forced through. It is only used
//                     when ROM_ARB_STARVE_GUARD_EN is defined.
//
//  Configuration macro
//    ROM_ARB_STARVE_GUARD_EN
//                     defined   : a starvation counter forces a debug grant
//                                 after STARVE_LIMIT cycles of waiting.
//                     undefined : strict fetch priority. Debug is granted
//                                 only while iFetchReq is low.
//
//  Ports
//    Clock            in   1   sole clock, rising edge
//    Reset            in   1   synchronous, active-high
//    iFetchReq        in   1   CPU fetch request
//    iFetchAddr       in  16   CPU fetch address
//    oFetchGrant      out  1   fetch accepted at this edge (combinational)
//    oFetchValid      out  1   one-cycle pulse, oFetchData is valid
//    oFetchData       out 28   instruction returned to the CPU
//    iDbgReq          in   1   debug read request
//    iDbgAddr         in  16   debug read address
//    oDbgGrant        out  1   debug accepted at this edge (combinational)
//    oDbgValid        out  1   one-cycle pulse, oDbgData is valid
//    oDbgData         out 28   instruction word returned to the debug port
//    oRomAddress      out 16   registered ROM address
//    iRomInstruction  in  28   ROM output for oRomAddress
// ============================================================================
`default_nettype none

module rom_port_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        iFetchReq,
   input  logic [15:0] iFetchAddr,
   output logic        oFetchGrant,
   output logic        oFetchValid,
   output logic [27:0] oFetchData,
   input  logic        iDbgReq,
   input  logic [15:0] iDbgAddr,
   output logic        oDbgGrant,
   output logic        oDbgValid,
   output logic [27:0] oDbgData,
   output logic [15:0] oRomAddress,
   input  logic [27:0] iRomInstruction
);

   // Elaboration-time guard. The counter is 4 bits wide, and a limit of 0
   // would lock out fetch.
   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
      $error("rom_port_arbiter: STARVE_LIMIT must be within 1..15");
   end

   // The owner records which port the address in oRomAddress belongs to.
   // That lets the edge after acceptance route iRomInstruction to the right
   // data register.
   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_DBG   = 2'd2
   } owner_t;

   owner_t owner;
   logic   starve_force;

`ifdef ROM_ARB_STARVE_GUARD_EN
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   logic [3:0] starve_cnt;

   // Force only while a debug request is actually pending. This keeps the
   // override from blocking fetch on a cycle where the counter has not yet
   // caught up with a dropped request.
   assign starve_force = iDbgReq && (starve_cnt == STARVE_MAX);

   // Counts the cycles debug spends waiting behind fetch, and saturates at
   // the limit. It clears once debug wins or once the request goes away.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         starve_cnt <= 4'd0;
      end else if (!iDbgReq || oDbgGrant) begin
         starve_cnt <= 4'd0;
      end else if (starve_cnt != STARVE_MAX) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end
`else
   assign starve_force = 1'b0;
`endif

   // The grants depend only on the request lines, Reset and the starvation
   // state. They have no path from the addresses or the ROM data. The two
   // terms cannot both be true, so the grants are mutually exclusive by
   // construction.
   assign oFetchGrant = !Reset && iFetchReq && !starve_force;
   assign oDbgGrant   = !Reset && iDbgReq   && (!iFetchReq || starve_force);

   // Two-stage pipeline.
   //   Acceptance edge : latch the winner's address and its owner.
   //   Next edge       : capture the ROM output into the owner's data
   //                     register and pulse that port's valid.
   // Reset clears the owner, so a read still in flight never produces a
   // valid pulse.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         owner       <= OWN_NONE;
         oRomAddress <= 16'd0;
         oFetchValid <= 1'b0;
         oDbgValid   <= 1'b0;
         oFetchData  <= 28'd0;
         oDbgData    <= 28'd0;
      end else begin
         // Return stage. The data registers hold their value when their
         // port is not the owner.
         oFetchValid <= 1'b0;
         oDbgValid   <= 1'b0;
         case (owner)
            OWN_FETCH: begin
               oFetchData  <= iRomInstruction;
               oFetchValid <= 1'b1;
            end
            OWN_DBG: begin
               oDbgData  <= iRomInstruction;
               oDbgValid <= 1'b1;
            end
            default: ;
         endcase

         // Acceptance stage. When nothing is granted, the address register
         // holds its value.
         if (oFetchGrant) begin
            oRomAddress <= iFetchAddr;
            owner       <= OWN_FETCH;
         end else if (oDbgGrant) begin
            oRomAddress <= iDbgAddr;
            owner       <= OWN_DBG;
         end else begin
            owner <= OWN_NONE;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rom_port_arbiter.sv
// ============================================================================
//  Module   : tb_rom_port_arbiter
//  Purpose  : Self-checking bench for rom_port_arbiter. It applies
//             table-driven directed vectors, then runs hand-written
//             arbitration sequences. Expectations for the contention
//             sequence follow ROM_ARB_STARVE_GUARD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_port_arbiter;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        iFetchReq;
   logic [15:0] iFetchAddr;
   logic        oFetchGrant;
   logic        oFetchValid;
   logic [27:0] oFetchData;
   logic        iDbgReq;
   logic [15:0] iDbgAddr;
   logic        oDbgGrant;
   logic        oDbgValid;
   logic [27:0] oDbgData;
   logic [15:0] oRomAddress;
   logic [27:0] iRomInstruction;

   int vectors     = 0;
   int miscompares = 0;

   always #5 Clock = ~Clock;

   // ROM model: a fixed function of the address, distinct for every address
   // used and never zero.
   function automatic logic [27:0] rom(input logic [15:0] a);
      return {4'hA, a[7:0] ^ 8'h3C, a};
   endfunction

   assign iRomInstruction = rom(oRomAddress);

   rom_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .Clock           (Clock),
      .Reset           (Reset),
      .iFetchReq       (iFetchReq),
      .iFetchAddr      (iFetchAddr),
      .oFetchGrant     (oFetchGrant),
      .oFetchValid     (oFetchValid),
      .oFetchData      (oFetchData),
      .iDbgReq         (iDbgReq),
      .iDbgAddr        (iDbgAddr),
      .oDbgGrant       (oDbgGrant),
      .oDbgValid       (oDbgValid),
      .oDbgData        (oDbgData),
      .oRomAddress     (oRomAddress),
      .iRomInstruction (iRomInstruction)
   );

   // Each row covers one cycle.
   //   Inputs           : the values driven during that cycle.
   //   Expected grants  : the combinational response within the cycle.
   //   Expected others  : the registered state produced by earlier edges.
   typedef struct {
      logic        rst;
      logic        freq;
      logic [15:0] faddr;
      logic        dreq;
      logic [15:0] daddr;
      logic        fg;
      logic        dg;
      logic [15:0] ra;
      logic        fv;
      logic [27:0] fd;
      logic        dv;
      logic [27:0] dd;
   } vec_t;

   localparam int NVEC = 20;
   vec_t vecs [NVEC];

   function automatic vec_t mk(
      input logic rst, input logic freq, input logic [15:0] faddr,
      input logic dreq, input logic [15:0] daddr,
      input logic fg, input logic dg, input logic [15:0] ra,
      input logic fv, input logic [27:0] fd,
      input logic dv, input logic [27:0] dd);
      vec_t v;
      v.rst = rst; v.freq = freq; v.faddr = faddr; v.dreq = dreq; v.daddr = daddr;
      v.fg = fg; v.dg = dg; v.ra = ra; v.fv = fv; v.fd = fd; v.dv = dv; v.dd = dd;
      return v;
   endfunction

   task automatic check(input string name, input int idx,
                        input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @%0d: got %h, expected %h", name, idx, act, exp);
      end
   endtask

   // Drive inputs just after the falling edge, then let them settle briefly
   // before sampling.
   task automatic drive(input logic rst, input logic fr, input logic [15:0] fa,
                        input logic dr, input logic [15:0] da);
      @(negedge Clock);
      Reset = rst; iFetchReq = fr; iFetchAddr = fa; iDbgReq = dr; iDbgAddr = da;
      #1;
   endtask

   initial begin
      Reset = 1'b1; iFetchReq = 1'b0; iFetchAddr = 16'd0;
      iDbgReq = 1'b0; iDbgAddr = 16'd0;
      repeat (2) @(posedge Clock);

      //              rst  fr  faddr dr  daddr  fg  dg  ra   fv  fd       dv  dd
      vecs[0]  = mk(1'b1,1'b1,16'd5, 1'b0,16'd0, 1'b0,1'b0,16'd0, 1'b0,28'd0,  1'b0,28'd0);
      vecs[1]  = mk(1'b0,1'b1,16'd3, 1'b0,16'd0, 1'b1,1'b0,16'd0, 1'b0,28'd0,  1'b0,28'd0);
      vecs[2]  = mk(1'b0,1'b0,16'd0, 1'b0,16'd0, 1'b0,1'b0,16'd3, 1'b0,28'd0,  1'b0,28'd0);
      vecs[3]  = mk(1'b0,1'b0,16'd0, 1'b0,16'd0, 1'b0,1'b0,16'd3, 1'b1,rom(3), 1'b0,28'd0);
      vecs[4]  = mk(1'b0,1'b1,16'd0, 1'b0,16'd0, 1'b1,1'b0,16'd3, 1'b0,rom(3), 1'b0,28'd0);
      vecs[5]  = mk(1'b0,1'b1,16'd1, 1'b0,16'd0, 1'b1,1'b0,16'd0, 1'b0,rom(3), 1'b0,28'd0);
      vecs[6]  = mk(1'b0,1'b1,16'd2, 1'b0,16'd0, 1'b1,1'b0,16'd1, 1'b1,rom(0), 1'b0,28'd0);
      vecs[7]  = mk(1'b0,1'b0,16'd0, 1'b0,16'd0, 1'b0,1'b0,16'd2, 1'b1,rom(1), 1'b0,28'd0);
      vecs[8]  = mk(1'b0,1'b0,16'd0, 1'b1,16'd15,1'b0,1'b1,16'd2, 1'b1,rom(2), 1'b0,28'd0);
      vecs[9]  = mk(1'b0,1'b0,16'd0, 1'b0,16'd0, 1'b0,1'b0,16'd15,1'b0,rom(2), 1'b0,28'd0);
      vecs[10] = mk(1'b0,1'b0,16'd0, 1'b0,16'd0, 1'b0,1'b0,16'd15,1'b0,rom(2), 1'b1,rom(15));
      vecs[11] = mk(1'b0,1'b0,16'd0, 1'b0,16'd0, 1'b0,1'b0,16'd15,1'b0,rom(2), 1'b0,rom(15));
      vecs[12] = mk(1'b0,1'b1,16'd7, 1'b0,16'd0, 1'b1,1'b0,16'd15,1'b0,rom(2), 1'b0,rom(15));
      vecs[13] = mk(1'b0,1'b0,16'd0, 1'b1,16'd8, 1'b0,1'b1,16'd7, 1'b0,rom(2), 1'b0,rom(15));
      vecs[14] = mk(1'b0,1'b0,16'd0, 1'b0,16'd0, 1'b0,1'b0,16'd8, 1'b1,rom(7), 1'b0,rom(15));
      vecs[15] = mk(1'b0,1'b0,16'd0, 1'b0,16'd0, 1'b0,1'b0,16'd8, 1'b0,rom(7), 1'b1,rom(8));
      vecs[16] = mk(1'b0,1'b1,16'd12,1'b0,16'd0, 1'b1,1'b0,16'd8, 1'b0,rom(7), 1'b0,rom(8));
      vecs[17] = mk(1'b1,1'b0,16'd0, 1'b0,16'd0, 1'b0,1'b0,16'd12,1'b0,rom(7), 1'b0,rom(8));
      vecs[18] = mk(1'b0,1'b0,16'd0, 1'b0,16'd0, 1'b0,1'b0,16'd0, 1'b0,28'd0,  1'b0,28'd0);
      vecs[19] = mk(1'b0,1'b0,16'd0, 1'b0,16'd0, 1'b0,1'b0,16'd0, 1'b0,28'd0,  1'b0,28'd0);

      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i].rst, vecs[i].freq, vecs[i].faddr, vecs[i].dreq, vecs[i].daddr);
         check("fetch_grant", i, 32'(oFetchGrant), 32'(vecs[i].fg));
         check("dbg_grant",   i, 32'(oDbgGrant),   32'(vecs[i].dg));
         check("rom_address", i, 32'(oRomAddress), 32'(vecs[i].ra));
         check("fetch_valid", i, 32'(oFetchValid), 32'(vecs[i].fv));
         check("fetch_data",  i, 32'(oFetchData),  32'(vecs[i].fd));
         check("dbg_valid",   i, 32'(oDbgValid),   32'(vecs[i].dv));
         check("dbg_data",    i, 32'(oDbgData),    32'(vecs[i].dd));
      end

      // Contention: fetch at address 6 and debug at address 9, both held.
`ifdef ROM_ARB_STARVE_GUARD_EN
      // Four fetch grants, then debug is forced through on the fifth cycle.
      // The counter then restarts, so debug waits another four cycles.
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < 4; c++) begin
            drive(1'b0, 1'b1, 16'd6, 1'b1, 16'd9);
            check("starve_fetch_grant", r*10 + c, 32'(oFetchGrant), 32'd1);
            check("starve_dbg_grant",   r*10 + c, 32'(oDbgGrant),   32'd0);
         end
         drive(1'b0, 1'b1, 16'd6, 1'b1, 16'd9);
         check("forced_dbg_grant",   r, 32'(oDbgGrant),   32'd1);
         check("forced_fetch_grant", r, 32'(oFetchGrant), 32'd0);
         if (r == 0) begin
            drive(1'b0, 1'b1, 16'd6, 1'b1, 16'd9);
            check("forced_rom_address", 0, 32'(oRomAddress), 32'd9);
            check("post_force_fetch_grant", 0, 32'(oFetchGrant), 32'd1);
            drive(1'b0, 1'b1, 16'd6, 1'b1, 16'd9);
            check("forced_dbg_valid", 0, 32'(oDbgValid),   32'd1);
            check("forced_dbg_data",  0, 32'(oDbgData),    32'(rom(16'd9)));
            check("forced_fetch_vld", 0, 32'(oFetchValid), 32'd0);
            // Two of the next four fetch grants are already spent above.
            for (int c = 0; c < 2; c++) begin
               drive(1'b0, 1'b1, 16'd6, 1'b1, 16'd9);
               check("restart_fetch_grant", c, 32'(oFetchGrant), 32'd1);
            end
            drive(1'b0, 1'b1, 16'd6, 1'b1, 16'd9);
            check("restart_dbg_grant", 0, 32'(oDbgGrant), 32'd1);
            r = 2;
         end
      end
`else
      // Strict priority: debug waits for as long as fetch is requesting.
      for (int c = 0; c < 8; c++) begin
         drive(1'b0, 1'b1, 16'd6, 1'b1, 16'd9);
         check("prio_fetch_grant", c, 32'(oFetchGrant), 32'd1);
         check("prio_dbg_grant",   c, 32'(oDbgGrant),   32'd0);
      end
      drive(1'b0, 1'b0, 16'd6, 1'b1, 16'd9);
      check("released_dbg_grant",   0, 32'(oDbgGrant),   32'd1);
      check("released_fetch_grant", 0, 32'(oFetchGrant), 32'd0);
      check("prio_fetch_valid",     0, 32'(oFetchValid), 32'd1);
      check("prio_fetch_data",      0, 32'(oFetchData),  32'(rom(16'd6)));
      drive(1'b0, 1'b0, 16'd0, 1'b0, 16'd0);
      check("released_rom_address", 0, 32'(oRomAddress), 32'd9);
      drive(1'b0, 1'b0, 16'd0, 1'b0, 16'd0);
      check("released_dbg_valid",   0, 32'(oDbgValid),   32'd1);
      check("released_dbg_data",    0, 32'(oDbgData),    32'(rom(16'd9)));
      check("released_fetch_valid", 0, 32'(oFetchValid), 32'd0);
`endif

      // Back-to-back debug then fetch with no idle cycle in between.
      // Returns come out in acceptance order.
      drive(1'b0, 1'b0, 16'd0, 1'b1, 16'd20);
      check("b2b_dbg_grant", 0, 32'(oDbgGrant), 32'd1);
      drive(1'b0, 1'b1, 16'd21, 1'b0, 16'd0);
      check("b2b_fetch_grant", 0, 32'(oFetchGrant), 32'd1);
      drive(1'b0, 1'b0, 16'd0, 1'b0, 16'd0);
      check("b2b_dbg_valid",  0, 32'(oDbgValid),   32'd1);
      check("b2b_dbg_data",   0, 32'(oDbgData),    32'(rom(16'd20)));
      check("b2b_fetch_low",  0, 32'(oFetchValid), 32'd0);
      drive(1'b0, 1'b0, 16'd0, 1'b0, 16'd0);
      check("b2b_fetch_valid", 0, 32'(oFetchValid), 32'd1);
      check("b2b_fetch_data",  0, 32'(oFetchData),  32'(rom(16'd21)));
      check("b2b_dbg_low",     0, 32'(oDbgValid),   32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
